// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared constants, types and helpers for the register file with scoreboard.
//   RF_XLEN / RF_DEPTH / RF_NUM_RD : default data width, register count and
//                                   number of read ports
//   rf_addr_t / rf_data_t          : default address and data types
//   popcount                       : number of set bits in a busy vector
// ----------------------------------------------------------------------------
package rf_pkg;

   localparam int RF_XLEN   = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_NUM_RD = 2;

   typedef logic [4:0]  rf_addr_t;
   typedef logic [31:0] rf_data_t;

   function automatic int unsigned popcount(input logic [RF_DEPTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int k = 0; k < RF_DEPTH; k++) begin
         n += int'(v[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy bits and a pending-write counter.
// Ports:
//   clk         in  clock, rising edge
//   rst_n_i     in  asynchronous active-low reset
//   flush_i     in  clear every busy bit (also drops a same-cycle issue)
//   iss_valid_i in  issue with destination iss_rd_i -> mark busy
//   iss_rd_i    in  destination register of the issue
//   we0_i/wa0_i in  writeback port 0 enable/address (retires busy)
//   we1_i/wa1_i in  writeback port 1 enable/address (retires busy)
//   busy_o      out registered busy vector (bit 0 always 0)
//   pend_cnt_o  out number of set busy bits
// ----------------------------------------------------------------------------
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             iss_valid_i,
   input  logic [AW-1:0]    iss_rd_i,
   input  logic             we0_i,
   input  logic [AW-1:0]    wa0_i,
   input  logic             we1_i,
   input  logic [AW-1:0]    wa1_i,
   output logic [DEPTH-1:0] busy_o,
   output logic [AW:0]      pend_cnt_o
);

   localparam logic signed [AW+2:0] CNT_MAX = (AW+3)'(DEPTH-1);

   logic [DEPTH-1:0]     busy_q, busy_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic                 set_new, clr0, clr1, iss_eff;
   logic signed [AW+2:0] cnt_sum;

   // Clamp the incremental count into 0..DEPTH-1.
   function automatic logic [AW:0] sat_cnt(input logic signed [AW+2:0] v);
      if (v[AW+2]) begin
         return '0;
      end
      if (v > CNT_MAX) begin
         return CNT_MAX[AW:0];
      end
      return v[AW:0];
   endfunction

   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         if (we0_i) busy_d[wa0_i] = 1'b0;
         if (we1_i) busy_d[wa1_i] = 1'b0;
         // Set is applied last: a newer producer beats a same-cycle retire.
         if (iss_valid_i) busy_d[iss_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Count deltas mirror exactly the bits that change state, so the
   // counter tracks popcount(busy) without ever recounting.
   always_comb begin
      iss_eff = iss_valid_i && (iss_rd_i != '0);
      set_new = iss_eff && !busy_q[iss_rd_i];
      clr0    = we0_i && (wa0_i != '0) && busy_q[wa0_i] &&
                !(iss_eff && (iss_rd_i == wa0_i));
      // A retire on port 1 to the same register as port 0 is counted once.
      clr1    = we1_i && (wa1_i != '0) && busy_q[wa1_i] &&
                !(iss_eff && (iss_rd_i == wa1_i)) &&
                !(we0_i && (wa0_i == wa1_i));
      cnt_sum = $signed({2'b00, cnt_q})
              + $signed({{(AW+2){1'b0}}, set_new})
              - $signed({{(AW+2){1'b0}}, clr0})
              - $signed({{(AW+2){1'b0}}, clr1});
      cnt_d   = flush_i ? '0 : sat_cnt(cnt_sum);
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o     = busy_q;
   assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// ----------------------------------------------------------------------------
// register_file_sb
// Multi-port register file (NUM_RD combinational reads, 2 writes) with a
// per-register busy scoreboard for hazard detection. Entry 0 reads as zero.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ra / rd / rd_busy read addresses, read data, busy status (packed per port)
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1 (wins over port 0 on the same address)
//   iss_valid/iss_rd  issue: mark destination busy
//   flush             clear all pending entries
//   pend_cnt          number of busy registers
// Build option: define RF_BYPASS_EN for same-cycle write-through forwarding
// to the read ports (forwarded reads also report not-busy).
// ----------------------------------------------------------------------------
module register_file_sb
   import rf_pkg::*;
#(
   parameter  int XLEN   = RF_XLEN,
   parameter  int DEPTH  = RF_DEPTH,
   parameter  int NUM_RD = RF_NUM_RD,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   ra,
   output logic [NUM_RD*XLEN-1:0] rd,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic                   we0,
   input  logic [AW-1:0]          wa0,
   input  logic [XLEN-1:0]        wd0,
   input  logic                   we1,
   input  logic [AW-1:0]          wa1,
   input  logic [XLEN-1:0]        wd1,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_rd,
   input  logic                   flush,
   output logic [AW:0]            pend_cnt
);

   logic [XLEN-1:0]  regs_q [DEPTH];
   logic [XLEN-1:0]  regs_d [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [AW-1:0]    rd_addr;
   logic [XLEN-1:0]  rd_data;
   logic             rd_bsy;

   rf_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sb (
      .clk         (clk),
      .rst_n_i     (rst),
      .flush_i     (flush),
      .iss_valid_i (iss_valid),
      .iss_rd_i    (iss_rd),
      .we0_i       (we0),
      .wa0_i       (wa0),
      .we1_i       (we1),
      .wa1_i       (wa1),
      .busy_o      (busy),
      .pend_cnt_o  (pend_cnt)
   );

   // Port 1 is applied after port 0 so it wins on an address collision.
   always_comb begin
      regs_d = regs_q;
      if (we0) regs_d[wa0] = wd0;
      if (we1) regs_d[wa1] = wd1;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd      = '0;
      rd_busy = '0;
      rd_addr = '0;
      rd_data = '0;
      rd_bsy  = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_addr = ra[i*AW +: AW];
         rd_data = regs_q[rd_addr];
         rd_bsy  = busy[rd_addr];
`ifdef RF_BYPASS_EN
         if (we0 && (wa0 == rd_addr)) begin
            rd_data = wd0;
            rd_bsy  = 1'b0;
         end
         if (we1 && (wa1 == rd_addr)) begin
            rd_data = wd1;
            rd_bsy  = 1'b0;
         end
`endif
         // x0 and the reset state both read as zero / not busy; gating on
         // rst also keeps forwarded data off the outputs while in reset.
         if ((rd_addr == '0) || !rst) begin
            rd_data = '0;
            rd_bsy  = 1'b0;
         end
         rd[i*XLEN +: XLEN] = rd_data;
         rd_busy[i]         = rd_bsy;
      end
   end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
   import rf_pkg::*;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [2*AW-1:0] ra;
   logic [2*XLEN-1:0] rd;
   logic [1:0]      rd_busy;
   logic            we0, we1, iss_valid, flush;
   logic [AW-1:0]   wa0, wa1, iss_rd;
   logic [XLEN-1:0] wd0, wd1;
   logic [AW:0]     pend_cnt;

   typedef struct {
      int        kind;  // 0 = rd data, 1 = rd_busy, 2 = pend_cnt
      int        port;
      rf_data_t  val;
      string     tag;
   } exp_t;

   exp_t sbq[$];
   int   vectors    = 0;
   int   miscompares = 0;

   register_file_sb dut (
      .clk       (clk),
      .rst       (rst),
      .ra        (ra),
      .rd        (rd),
      .rd_busy   (rd_busy),
      .we0       (we0),
      .wa0       (wa0),
      .wd0       (wd0),
      .we1       (we1),
      .wa1       (wa1),
      .wd1       (wd1),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
   endtask

   // Apply the currently driven controls on one edge, then return to idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic rda(input int a0, input int a1);
      ra = {AW'(a1), AW'(a0)};
      #1;
   endtask

   task automatic exp_rd(input int p, input rf_data_t v, input string t);
      sbq.push_back('{0, p, v, t});
   endtask

   task automatic exp_busy(input int p, input logic b, input string t);
      sbq.push_back('{1, p, rf_data_t'(b), t});
   endtask

   task automatic exp_cnt(input int c, input string t);
      sbq.push_back('{2, 0, rf_data_t'(c), t});
   endtask

   task automatic check();
      exp_t     e;
      rf_data_t obs;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.kind)
            0:       obs = rd[e.port*XLEN +: XLEN];
            1:       obs = rf_data_t'(rd_busy[e.port]);
            default: obs = rf_data_t'(pend_cnt);
         endcase
         vectors++;
         assert (obs === e.val)
         else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      idle();
      ra  = '0;
      rst = 1'b0;
      #12;
      rda(1, 2);
      exp_rd(0, 0, "in_reset_rd0"); exp_rd(1, 0, "in_reset_rd1");
      exp_busy(0, 0, "in_reset_busy0"); exp_cnt(0, "in_reset_cnt");
      check();
      @(negedge clk);
      rst = 1'b1;
      #1;

      // 1. Post-reset reads and x0 write
      rda(1, 2);
      exp_rd(0, 0, "rst_x1"); exp_rd(1, 0, "rst_x2");
      exp_busy(0, 0, "rst_busy0"); exp_busy(1, 0, "rst_busy1");
      exp_cnt(0, "rst_cnt");
      check();
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd55;
      cyc();
      rda(0, 0);
      exp_rd(0, 0, "x0_write_ignored");
      check();

      // 2. Write ports and port-1 priority
      we0 = 1'b1; wa0 = 5'd1; wd0 = 32'd10;
      cyc();
      rda(1, 0);
      exp_rd(0, 10, "x1_first_write");
      check();
      we0 = 1'b1; wa0 = 5'd1; wd0 = 32'd20;
      we1 = 1'b1; wa1 = 5'd1; wd1 = 32'd30;
      #1;
`ifdef RF_BYPASS_EN
      exp_rd(0, 30, "x1_bypass_port1");
`else
      exp_rd(0, 10, "x1_no_bypass_old");
`endif
      check();
      cyc();
      exp_rd(0, 30, "x1_port1_wins");
      check();

      // 3. Issue / write interplay on x5
      iss_valid = 1'b1; iss_rd = 5'd5;
      cyc();
      rda(5, 1);
      exp_busy(0, 1, "x5_busy_after_issue"); exp_cnt(1, "cnt_after_issue");
      check();
      iss_valid = 1'b1; iss_rd = 5'd5;
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'd7;
      cyc();
      #1;
      exp_rd(0, 7, "x5_written"); exp_busy(0, 1, "x5_set_wins");
      exp_cnt(1, "cnt_no_double");
      check();
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'd8;
      cyc();
      #1;
      exp_rd(0, 8, "x5_port1_write"); exp_busy(0, 0, "x5_retired");
      exp_cnt(0, "cnt_retired");
      check();

      // 4. Three issues then flush with same-cycle issue
      for (int r = 3; r <= 6; r++) begin
         if (r != 5) begin
            iss_valid = 1'b1; iss_rd = AW'(r);
            cyc();
         end
      end
      rda(6, 3);
      exp_cnt(3, "cnt_three"); exp_busy(0, 1, "x6_busy"); exp_busy(1, 1, "x3_busy");
      check();
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd7;
      cyc();
      rda(7, 3);
      exp_cnt(0, "cnt_flush"); exp_busy(0, 0, "x7_dropped"); exp_busy(1, 0, "x3_flushed");
      check();

      // 5. Dual retire, same-address dual write, fill to 31
      iss_valid = 1'b1; iss_rd = 5'd3; cyc();
      iss_valid = 1'b1; iss_rd = 5'd4; cyc();
      #1;
      exp_cnt(2, "cnt_two");
      check();
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd33;
      we1 = 1'b1; wa1 = 5'd4; wd1 = 32'd44;
      cyc();
      rda(3, 4);
      exp_cnt(0, "cnt_dual_retire"); exp_rd(0, 33, "x3_data"); exp_rd(1, 44, "x4_data");
      exp_busy(0, 0, "x3_idle"); exp_busy(1, 0, "x4_idle");
      check();
      iss_valid = 1'b1; iss_rd = 5'd2; cyc();
      iss_valid = 1'b1; iss_rd = 5'd3; cyc();
      we0 = 1'b1; wa0 = 5'd2; wd0 = 32'd1;
      we1 = 1'b1; wa1 = 5'd2; wd1 = 32'd2;
      cyc();
      rda(2, 3);
      exp_cnt(1, "cnt_same_addr_once"); exp_rd(0, 2, "x2_port1_data");
      exp_busy(0, 0, "x2_idle"); exp_busy(1, 1, "x3_still_busy");
      check();
      for (int r = 1; r < 32; r++) begin
         iss_valid = 1'b1; iss_rd = AW'(r);
         cyc();
      end
      rda(31, 0);
      exp_cnt(31, "cnt_full"); exp_busy(0, 1, "x31_busy"); exp_busy(1, 0, "x0_never_busy");
      check();
      iss_valid = 1'b1; iss_rd = 5'd1; cyc();
      iss_valid = 1'b1; iss_rd = 5'd0; cyc();
      #1;
      exp_cnt(31, "cnt_full_no_wrap");
      check();
      flush = 1'b1; cyc();
      #1;
      exp_cnt(0, "cnt_flush_full");
      check();

      // 6. Asynchronous reset mid-clock
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd99; cyc();
      iss_valid = 1'b1; iss_rd = 5'd10; cyc();
      rda(9, 10);
      exp_rd(0, 99, "x9_before_reset"); exp_busy(1, 1, "x10_busy"); exp_cnt(1, "cnt_pre_reset");
      check();
      @(posedge clk);
      #2;
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd77;
      iss_valid = 1'b1; iss_rd = 5'd11;
      rst = 1'b0;
      #1;
      exp_rd(0, 0, "async_rd0"); exp_busy(1, 0, "async_busy1"); exp_cnt(0, "async_cnt");
      check();
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      rda(9, 11);
      exp_rd(0, 0, "x9_after_release"); exp_busy(1, 0, "x11_dropped");
      exp_cnt(0, "cnt_after_release");
      check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
